mem_ctrl: RTL

- Sole owner of the 8-bit unified RAM/IO port. Arbitrates between instruction fetch and the load/store unit.
- Serialises each request into 1/2/4 byte-wide accesses and reassembles read bytes little-endian.
- Sits between the LSU and instruction fetch on one side and the top-level memory pins on the other.
- Aborts speculative loads and fetches on misbranch. Committed stores always run to completion.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the unified 8-bit RAM/IO port controller:
// state encoding, access size codes, IO page select and helpers.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LOAD  = 2'd2,
      ST_STORE = 2'd3
   } mc_state_e;

   localparam logic [1:0]  SIZE_B         = 2'b00;
   localparam logic [1:0]  SIZE_H         = 2'b01;
   localparam logic [1:0]  SIZE_W         = 2'b10;
   localparam logic [1:0]  IO_SEL_DEFAULT = 2'b11;
   localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

   // Byte count of an access; the reserved code 2'b11 is treated as a word.
   function automatic logic [2:0] size_len(input logic [1:0] sz);
      case (sz)
         SIZE_B:  return 3'd1;
         SIZE_H:  return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // IO-space predicate on addr[17:16].
   function automatic logic is_io_page(input logic [1:0] page, input logic [1:0] sel);
      return page == sel;
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and LSU onto the 8-bit RAM/IO port, serialising each
// request into byte accesses and reassembling reads little-endian.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              misbranch_flag,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              ls_req,
   input  logic              ls_is_store,
   input  logic [1:0]        ls_size,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   mc_state_e         state_q, state_d;
   logic [2:0]        cnt_q, cnt_d, len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d, mem_a_q, mem_a_d;
   logic [31:0]       wdata_q, wdata_d, rbuf_q, rbuf_d;
   logic [31:0]       if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
   logic              io_q, io_d, io_gap_q, io_gap_d;
   logic              if_done_q, if_done_d, ls_done_q, ls_done_d;
   logic [7:0]        mem_dout_q, mem_dout_d;
   logic              mem_wr_q, mem_wr_d;

   logic [2:0]  nxt_cnt;
   logic [1:0]  byte_idx;
   logic [31:0] rd_word;
   logic [7:0]  st_byte;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rbuf_d     = rbuf_q;
      io_d       = io_q;
      io_gap_d   = io_gap_q;
      if_done_d  = 1'b0;
      ls_done_d  = 1'b0;
      if_data_d  = if_data_q;
      ls_rdata_d = ls_rdata_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = 1'b0;

      nxt_cnt  = cnt_q + 3'd1;
      // cnt_q addresses byte cnt_q; the byte arriving now belongs to cnt_q-1.
      byte_idx = cnt_q[1:0] - 2'd1;
      rd_word  = rbuf_q;
      if (cnt_q != 3'd0)
         rd_word = rbuf_q | ({24'b0, mem_din} << {byte_idx, 3'b000});
      st_byte  = wdata_q[{nxt_cnt[1:0], 3'b000} +: 8];

      if (rdy) begin
         io_gap_d = mem_wr_q & io_q;
         case (state_q)
            ST_IDLE: begin
               mem_a_d = '0;
               if (!misbranch_flag && !io_gap_q) begin
                  if (ls_req && !ls_done_q) begin
                     addr_d  = ls_addr;
                     len_d   = size_len(ls_size);
                     wdata_d = ls_wdata;
                     cnt_d   = 3'd0;
                     rbuf_d  = ZERO_WORD;
                     mem_a_d = ls_addr;
                     io_d    = is_io_page(ls_addr[17:16], IO_SEL);
                     if (ls_is_store) begin
                        state_d    = ST_STORE;
                        mem_dout_d = ls_wdata[7:0];
                        mem_wr_d   = !(is_io_page(ls_addr[17:16], IO_SEL) && io_buffer_full);
                     end else begin
                        state_d = ST_LOAD;
                     end
                  end else if (if_req && !if_done_q) begin
                     state_d = ST_FETCH;
                     addr_d  = if_addr;
                     len_d   = 3'd4;
                     cnt_d   = 3'd0;
                     rbuf_d  = ZERO_WORD;
                     mem_a_d = if_addr;
                     io_d    = 1'b0;
                  end
               end
            end
            ST_FETCH, ST_LOAD: begin
               if (misbranch_flag) begin
                  state_d = ST_IDLE;
                  mem_a_d = '0;
               end else if (cnt_q == len_q) begin
                  state_d = ST_IDLE;
                  mem_a_d = '0;
                  if (state_q == ST_FETCH) begin
                     if_done_d = 1'b1;
                     if_data_d = rd_word;
                  end else begin
                     ls_done_d  = 1'b1;
                     ls_rdata_d = rd_word;
                  end
               end else begin
                  rbuf_d  = rd_word;
                  cnt_d   = nxt_cnt;
                  mem_a_d = addr_q + ADDR_W'(nxt_cnt);
               end
            end
            ST_STORE: begin
               if (mem_wr_q) begin
                  if (nxt_cnt == len_q) begin
                     state_d   = ST_IDLE;
                     mem_a_d   = '0;
                     ls_done_d = 1'b1;
                  end else begin
                     cnt_d      = nxt_cnt;
                     mem_a_d    = addr_q + ADDR_W'(nxt_cnt);
                     mem_dout_d = st_byte;
                     // IO writes are separated by a mandatory idle cycle.
                     mem_wr_d   = !io_q;
                  end
               end else begin
                  mem_wr_d = !(io_q && io_buffer_full);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         len_q      <= 3'd0;
         addr_q     <= '0;
         wdata_q    <= ZERO_WORD;
         rbuf_q     <= ZERO_WORD;
         io_q       <= 1'b0;
         io_gap_q   <= 1'b0;
         if_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
         if_data_q  <= ZERO_WORD;
         ls_rdata_q <= ZERO_WORD;
         mem_a_q    <= '0;
         mem_dout_q <= 8'h00;
         mem_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rbuf_q     <= rbuf_d;
         io_q       <= io_d;
         io_gap_q   <= io_gap_d;
         if_done_q  <= if_done_d;
         ls_done_q  <= ls_done_d;
         if_data_q  <= if_data_d;
         ls_rdata_q <= ls_rdata_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
      end
   end

   assign if_done  = if_done_q;
   assign if_data  = if_data_q;
   assign ls_done  = ls_done_q;
   assign ls_rdata = ls_rdata_q;
   assign mem_a    = mem_a_q;
   assign mem_dout = mem_dout_q;
   assign mem_wr   = mem_wr_q;

endmodule
